// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and counter sizing for the PLL reset sequencer.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package pll_seq_pkg;

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAIL      = 3'd4;

    // Width needed for one counter shared by every state's cycle budget.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 clk edges. Backpressure: none.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock wait with timeout/retry, lock qualification, design reset release.
// Latency: lock loss in RUN raises design_reset 3 clocks later. Backpressure: none.
// PLL_SEQ_RELOCK_EN: when defined, lock loss in RUN re-resets the PLL instead of re-qualifying.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       design_reset,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retries
);

    localparam int CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);

    logic          lock_s;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    retries_nxt;
    logic [3:0]    retries_inc;

    sync2 u_lock_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign retries_inc = (retries == 4'd15) ? 4'd15 : retries + 4'd1;

    always_comb begin
        state_nxt   = state;
        retries_nxt = retries;
        case (state)
            PLL_RST: begin
                if (cnt == CW'(PLL_RESET_CYCLES - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the retry.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retries_nxt = retries_inc;
                    state_nxt   = (retries_inc == 4'(MAX_RETRIES)) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
`ifdef PLL_SEQ_RELOCK_EN
                    state_nxt = PLL_RST;
`else
                    state_nxt = STABLE;
`endif
                end
            end
            FAIL:    state_nxt = FAIL;
            default: state_nxt = PLL_RST;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PLL_RST;
            cnt          <= '0;
            retries      <= 4'd0;
            pll_resetb   <= 1'b0;
            design_reset <= 1'b1;
            locked       <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state   <= state_nxt;
            retries <= retries_nxt;
            // RUN and FAIL have no budget, so the counter parks at zero there.
            if (state_nxt != state || state_nxt == RUN || state_nxt == FAIL) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            pll_resetb   <= (state_nxt != PLL_RST) && (state_nxt != FAIL);
            design_reset <= (state_nxt != RUN);
            locked       <= (state_nxt == RUN);
            fail         <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed-random bench for pll_reset_seq; expected edges come from the sequencing rules.
module tb_pll_reset_seq;

    localparam int PRC = 4;
    localparam int LTO = 32;
    localparam int LSC = 8;
    localparam int MR  = 2;
    // pll_lock is driven just after edge k: first flop captures at k+1,
    // second at k+2, and the FSM acts on it at edge k+3.
    localparam int SYNC_SEEN = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       pll_resetb;
    logic       design_reset;
    logic       locked;
    logic       fail;
    logic [3:0] retries;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    pll_reset_seq #(
        .PLL_RESET_CYCLES   (PRC),
        .LOCK_TIMEOUT       (LTO),
        .LOCK_STABLE_CYCLES (LSC),
        .MAX_RETRIES        (MR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .pll_resetb   (pll_resetb),
        .design_reset (design_reset),
        .locked       (locked),
        .fail         (fail),
        .retries      (retries)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edges until pll_resetb shows val; -1 if it never does.
    task automatic wait_rb(input logic val, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (pll_resetb === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Edge number at which design_reset is first seen low; -1 if never.
    task automatic wait_dr_low(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (design_reset === 1'b0) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Release edge for a lock raised just after edge k and then held.
    function automatic int release_edge(input int k);
        return k + SYNC_SEEN + LSC;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, k, r, at, d, w, exp_ent, exp_ret;
        logic ok;

        reset_n  = 1'b0;
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("rst_pll_resetb", pll_resetb, 0);
        chk("rst_design_reset", design_reset, 1);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retries", retries, 0);

        reset_n = 1'b1;
        wait_rb(1'b1, n);
        chk("prst_len_boot", n, PRC);

        // Nominal lock and release
        d = $urandom_range(6, 14);
        repeat (d) tick();
        pll_lock = 1'b1;
        k = cyc;
        wait_dr_low(at);
        chk("nominal_release", at - k, release_edge(k) - k);
        chk("nominal_locked", locked, 1);
        chk("nominal_rb", pll_resetb, 1);
        chk("nominal_retries", retries, 0);

        // Lock loss in RUN
        repeat ($urandom_range(2, 10)) tick();
        pll_lock = 1'b0;
        k = cyc;
        repeat (SYNC_SEEN - 1) tick();
        chk("loss_not_early", design_reset, 0);
        tick();
        chk("loss_dr", design_reset, 1);
        chk("loss_locked", locked, 0);
`ifdef PLL_SEQ_RELOCK_EN
        chk("relock_rb_low", pll_resetb, 0);
        wait_rb(1'b1, n);
        chk("relock_prst_len", n, PRC);
        repeat ($urandom_range(0, 5)) tick();
`else
        ok = 1'b1;
        d  = $urandom_range(4, 8);
        while (cyc < k + d) begin
            tick();
            if (pll_resetb !== 1'b1) ok = 1'b0;
        end
        chk("loss_rb_held_high", ok, 1);
`endif
        pll_lock = 1'b1;
        r = cyc;
        wait_dr_low(at);
        chk("relock_release", at - r, release_edge(r) - r);
        chk("relock_retries", retries, 0);

        // Async reset while qualifying lock
        pll_lock = 1'b0;
        repeat (12) tick();
        pll_lock = 1'b1;
        repeat (SYNC_SEEN + 4) tick();
        chk("stable_rb_before", pll_resetb, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_rb", pll_resetb, 0);
        chk("arst_dr", design_reset, 1);
        chk("arst_locked", locked, 0);
        pll_lock = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_rb(1'b1, n);
        chk("prst_len_arst", n, PRC);

        // Lock glitch during qualification restarts it
        repeat ($urandom_range(1, 10)) tick();
        pll_lock = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
        pll_lock = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        pll_lock = 1'b1;
        r = cyc;
        wait_dr_low(at);
        chk("glitch_release", at - r, release_edge(r) - r);
        chk("glitch_retries", retries, 0);

        // Lock arriving exactly at, or one edge after, the timeout
        pll_lock = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_rb(1'b1, n);
        chk("prst_len_sim", n, PRC);
        w = cyc;
        d = $urandom_range(0, 1);
        repeat (LTO - SYNC_SEEN + d) tick();
        pll_lock = 1'b1;
        k = cyc;
        if (k + SYNC_SEEN <= w + LTO) begin
            exp_ent = k + SYNC_SEEN;
            exp_ret = 0;
        end else begin
            exp_ent = w + LTO + PRC + 1;
            exp_ret = 1;
        end
        wait_dr_low(at);
        chk("sim_release", at, exp_ent + LSC);
        chk("sim_retries", retries, exp_ret);

        // Timeouts up to FAIL
        pll_lock = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_rb(1'b1, n);
        chk("prst_len_to", n, PRC);
        for (int t = 1; t <= MR; t++) begin
            wait_rb(1'b0, n);
            chk("timeout_len", n, LTO);
            chk("timeout_retries", retries, t);
            chk("timeout_fail", fail, (t == MR) ? 1 : 0);
            if (t < MR) begin
                wait_rb(1'b1, n);
                chk("retry_prst_len", n, PRC);
            end
        end
        ok = 1'b1;
        repeat (50) begin
            tick();
            if (pll_resetb !== 1'b0 || fail !== 1'b1 || design_reset !== 1'b1) ok = 1'b0;
        end
        chk("fail_terminal", ok, 1);
        chk("fail_locked", locked, 0);
        chk("fail_retries", retries, MR);

        #3 reset_n = 1'b0;
        #1;
        chk("arst_fail_clear", fail, 0);
        chk("arst_retries_clear", retries, 0);
        tick();
        reset_n = 1'b1;
        wait_rb(1'b1, n);
        chk("prst_len_final", n, PRC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
